// File: rtl/classifier_pkg.sv
// Shared constants for the colour-classifier threshold register bank.
package classifier_pkg;

   localparam int unsigned CFG_W     = 9;
   localparam int unsigned N_FIELDS  = 12;
   localparam int unsigned CFG_BUS_W = CFG_W * N_FIELDS;
   localparam int unsigned ADDR_W    = 4;

   localparam int unsigned F_SMIN      = 0;
   localparam int unsigned F_VMIN      = 1;
   localparam int unsigned F_RED_LO    = 2;
   localparam int unsigned F_RED_HI    = 3;
   localparam int unsigned F_YELLOW_LO = 4;
   localparam int unsigned F_YELLOW_HI = 5;
   localparam int unsigned F_GREEN_LO  = 6;
   localparam int unsigned F_GREEN_HI  = 7;
   localparam int unsigned F_BLUE_LO   = 8;
   localparam int unsigned F_BLUE_HI   = 9;
   localparam int unsigned F_PINK_LO   = 10;
   localparam int unsigned F_PINK_HI   = 11;

   localparam logic [ADDR_W-1:0] ADDR_CTRL       = 4'd12;
   localparam logic [ADDR_W-1:0] ADDR_ACTIVE_SEL = 4'd13;
   localparam logic [ADDR_W-1:0] ADDR_COMMIT_CNT = 4'd14;
   localparam logic [ADDR_W-1:0] ADDR_ID         = 4'd15;

   localparam logic [31:0] ID_VALUE = 32'h434C_4346;

   // Packed so that element k occupies bits [CFG_W*k +: CFG_W] of the bus.
   typedef logic [N_FIELDS-1:0][CFG_W-1:0] cfg_bank_t;

   localparam cfg_bank_t DEFAULT_CFG = {
      9'd330, 9'd270,   // pink hi / lo
      9'd250, 9'd200,   // blue
      9'd180, 9'd160,   // green
      9'd70,  9'd50,    // yellow
      9'd330, 9'd30,    // red
      9'd128, 9'd153    // V min / S min
   };

endpackage

// File: rtl/classifier_cfg_regs_if.sv
// Avalon-MM slave bus bundle for the classifier configuration registers.
interface classifier_cfg_regs_if;
   import classifier_pkg::*;

   logic [ADDR_W-1:0] avs_address;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic              avs_read;
   logic [31:0]       avs_readdata;
   logic              avs_readdatavalid;

   modport master (
      output avs_address, avs_write, avs_writedata, avs_read,
      input  avs_readdata, avs_readdatavalid
   );

   modport slave (
      input  avs_address, avs_write, avs_writedata, avs_read,
      output avs_readdata, avs_readdatavalid
   );

endinterface

// File: rtl/classifier_cfg_check.sv
// Combinational lo < hi validator for the non-wrapping colour ranges.
module classifier_cfg_check
   import classifier_pkg::*;
(
   input  cfg_bank_t cfg,
   output logic      ok
);

   // Red wraps around hue zero, so it is deliberately not checked.
   always_comb begin
      ok = (cfg[F_YELLOW_LO] < cfg[F_YELLOW_HI]) &&
           (cfg[F_GREEN_LO]  < cfg[F_GREEN_HI])  &&
           (cfg[F_BLUE_LO]   < cfg[F_BLUE_HI])   &&
           (cfg[F_PINK_LO]   < cfg[F_PINK_HI]);
   end

endmodule

// File: rtl/classifier_cfg_regs.sv
// Shadow/active threshold register bank; active bank updates on sop or immediate commit.
// Optional commit-time range check enabled by CLASSIFIER_CFG_CHECK_EN.
module classifier_cfg_regs
   import classifier_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   classifier_cfg_regs_if.slave avs,
   input  logic                 sop,
   output logic [CFG_BUS_W-1:0] classifier_config,
   output logic                 commit_pending
);

   cfg_bank_t   shadow_q, shadow_d;
   cfg_bank_t   active_q, active_d;
   logic        pending_q, pending_d;
   logic        err_q, err_d;
   logic        sel_q, sel_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q;

   logic field_wr, ctrl_wr, do_commit, cfg_ok;

`ifdef CLASSIFIER_CFG_CHECK_EN
   classifier_cfg_check u_check (
      .cfg (shadow_q),
      .ok  (cfg_ok)
   );
`else
   assign cfg_ok = 1'b1;
`endif

   always_comb begin
      field_wr  = avs.avs_write && (avs.avs_address < ADDR_CTRL);
      ctrl_wr   = avs.avs_write && (avs.avs_address == ADDR_CTRL);
      do_commit = (ctrl_wr && avs.avs_writedata[1]) ||
                  (sop && (pending_q || (ctrl_wr && avs.avs_writedata[0])));

      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      err_d     = err_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;

      if (ctrl_wr && avs.avs_writedata[0]) pending_d = 1'b1;

      // A field write racing a commit stays in shadow and re-arms the next frame.
      if (do_commit) begin
         pending_d = field_wr;
         if (cfg_ok) begin
            active_d = shadow_q;
            cnt_d    = cnt_q + 16'd1;
         end
      end

`ifdef CLASSIFIER_CFG_CHECK_EN
      if (do_commit)                             err_d = !cfg_ok;
      else if (ctrl_wr && avs.avs_writedata[2])  err_d = 1'b0;
`else
      err_d = 1'b0;
`endif

      if (field_wr) shadow_d[avs.avs_address] = avs.avs_writedata[CFG_W-1:0];
      if (avs.avs_write && (avs.avs_address == ADDR_ACTIVE_SEL)) sel_d = avs.avs_writedata[0];
   end

   // Read mux sees pre-write state, so a same-cycle write is not visible.
   always_comb begin
      rdata_d = rdata_q;
      if (avs.avs_read) begin
         if (avs.avs_address < ADDR_CTRL) begin
            rdata_d = sel_q ? 32'(active_q[avs.avs_address]) : 32'(shadow_q[avs.avs_address]);
         end else begin
            case (avs.avs_address)
               ADDR_CTRL:       rdata_d = {29'b0, err_q, 1'b0, pending_q};
               ADDR_ACTIVE_SEL: rdata_d = {31'b0, sel_q};
               ADDR_COMMIT_CNT: rdata_d = {16'b0, cnt_q};
               default:         rdata_d = ID_VALUE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q  <= DEFAULT_CFG;
         active_q  <= DEFAULT_CFG;
         pending_q <= 1'b0;
         err_q     <= 1'b0;
         sel_q     <= 1'b0;
         cnt_q     <= 16'd0;
         rdata_q   <= 32'd0;
         rvalid_q  <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         err_q     <= err_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= avs.avs_read;
      end
   end

   assign classifier_config     = active_q;
   assign commit_pending        = pending_q;
   assign avs.avs_readdata      = rdata_q;
   assign avs.avs_readdatavalid = rvalid_q;

endmodule
